burst_sequencer: RTL and testbench



---
 rtl/burst_seq_pkg.sv | 21 ++
 rtl/burst_sequencer_trig_sync_edge.sv | 29 ++
 rtl/burst_sequencer.sv | 154 +++++++++++++++
 tb/tb_burst_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/burst_seq_pkg.sv
// Shared types and constants for the burst sequencer.
// State encoding, control bit indices and status word layout.
package burst_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam int CTL_EN       = 0;
   localparam int CTL_SW_TRIG  = 1;
   localparam int CTL_EXT_EN   = 2;
   localparam int CTL_EXT_FALL = 3;

   localparam int ST_BUSY      = 15;
   localparam int ST_ABORT     = 14;
   localparam int ST_STATE_MSB = 13;
   localparam int ST_STATE_LSB = 12;

endpackage

// File: rtl/burst_sequencer_trig_sync_edge.sv
// Multi-flop synchroniser followed by a rise/fall edge detector.
// Clears to 0, so a level held through reset reads as a rising edge.
module trig_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign rise = sync_q[STAGES-1] & ~prev_q;
   assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/burst_sequencer.sv
// Gated high/low pulse train generator driven by the FX2 register bank.
// Config is shadowed at burst start; triggers while busy are dropped.
module burst_sequencer
   import burst_seq_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0]      control_reg,
   input  logic [CNT_W-1:0] conf_1_reg,
   input  logic [CNT_W-1:0] conf_2_reg,
   input  logic [CNT_W-1:0] conf_3_reg,
   input  logic             ext_trig,
   output logic             pulse_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] cycles_done,
   output logic [15:0]      status_reg
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [CNT_W-1:0] hi_s, hi_n;
   logic [CNT_W-1:0] lo_s, lo_n;
   logic [CNT_W-1:0] n_s, n_n;
   logic [CNT_W-1:0] cyc_q, cyc_n, cyc_inc;
   logic [CNT_W-1:0] hi_c, lo_c;
   logic             aborted_q, aborted_n;
   logic             pulse_q, done_q, done_n;
   logic             en, sw_rise, ext_rise, ext_fall;
   logic             ext_edge, start;
   logic             unused_sw_fall;
   logic             unused_ctl;

   trig_sync_edge #(.STAGES(SYNC_STAGES)) u_sw (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (control_reg[CTL_SW_TRIG]),
      .rise (sw_rise),
      .fall (unused_sw_fall)
   );

   trig_sync_edge #(.STAGES(SYNC_STAGES)) u_ext (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (ext_trig),
      .rise (ext_rise),
      .fall (ext_fall)
   );

   assign unused_ctl = ^control_reg[15:4];
   assign en         = control_reg[CTL_EN];
   assign ext_edge   = control_reg[CTL_EXT_EN] &
                       (control_reg[CTL_EXT_FALL] ? ext_fall : ext_rise);
   assign start      = en & (sw_rise | ext_edge);

   // A zero phase length still produces one cycle
   assign hi_c    = (conf_1_reg == '0) ? ONE : conf_1_reg;
   assign lo_c    = (conf_2_reg == '0) ? ONE : conf_2_reg;
   assign cyc_inc = cyc_q + ONE;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hi_s      <= '0;
         lo_s      <= '0;
         n_s       <= '0;
         cyc_q     <= '0;
         aborted_q <= 1'b0;
         pulse_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         hi_s      <= hi_n;
         lo_s      <= lo_n;
         n_s       <= n_n;
         cyc_q     <= cyc_n;
         aborted_q <= aborted_n;
         pulse_q   <= (state_n == HIGH);
         done_q    <= done_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      cnt_n     = cnt_q;
      hi_n      = hi_s;
      lo_n      = lo_s;
      n_n       = n_s;
      cyc_n     = cyc_q;
      aborted_n = aborted_q;
      done_n    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               hi_n      = hi_c;
               lo_n      = lo_c;
               n_n       = conf_3_reg;
               cnt_n     = hi_c - ONE;
               cyc_n     = '0;
               aborted_n = 1'b0;
               state_n   = HIGH;
            end
         end
         HIGH: begin
            if (!en) begin
               aborted_n = 1'b1;
               state_n   = IDLE;
            end else if (cnt_q != '0) begin
               cnt_n = cnt_q - ONE;
            end else begin
               cnt_n   = lo_s - ONE;
               state_n = LOW;
            end
         end
         LOW: begin
            if (!en) begin
               aborted_n = 1'b1;
               state_n   = IDLE;
            end else if (cnt_q != '0) begin
               cnt_n = cnt_q - ONE;
            end else begin
               cyc_n = cyc_inc;
               if (n_s != '0 && cyc_inc == n_s) begin
                  done_n  = 1'b1;
                  state_n = IDLE;
               end else begin
                  cnt_n   = hi_s - ONE;
                  state_n = HIGH;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state_q != IDLE);
      pulse_out   = pulse_q;
      done        = done_q;
      cycles_done = cyc_q;
      status_reg  = '0;
      status_reg[ST_BUSY]  = busy;
      status_reg[ST_ABORT] = aborted_q;
      status_reg[ST_STATE_MSB:ST_STATE_LSB] = state_q;
   end

endmodule

// File: tb/tb_burst_sequencer.sv
// Directed bench for burst_sequencer.
// Checks pulse timing, clamping, abort, shadowing, ext edges, reset.
module tb_burst_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] control_reg;
   logic [31:0] conf_1_reg, conf_2_reg, conf_3_reg;
   logic        ext_trig;
   logic        pulse_out, busy, done;
   logic [31:0] cycles_done;
   logic [15:0] status_reg;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   burst_sequencer #(.CNT_W(32), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .control_reg(control_reg),
      .conf_1_reg (conf_1_reg),
      .conf_2_reg (conf_2_reg),
      .conf_3_reg (conf_3_reg),
      .ext_trig   (ext_trig),
      .pulse_out  (pulse_out),
      .busy       (busy),
      .done       (done),
      .cycles_done(cycles_done),
      .status_reg (status_reg)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_sw(input string tag);
      control_reg[1] = 1'b1;
      step();
      chk({tag, "_sync1"}, {31'd0, busy}, 32'd0);
      step();
      chk({tag, "_sync2"}, {31'd0, busy}, 32'd0);
      control_reg[1] = 1'b0;
   endtask

   task automatic run_burst(input string tag, input int hi,
                            input int lo, input int n);
      int per;
      per = hi + lo;
      for (int i = 0; i < n * per; i++) begin
         step();
         chk({tag, "_pulse"}, {31'd0, pulse_out},
             ((i % per) < hi) ? 32'd1 : 32'd0);
         chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
         chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
      end
      step();
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
      chk({tag, "_cycles"}, cycles_done, n);
      step();
      chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
   endtask

   logic [9:0] pat1;

   initial begin
      rst_n       = 1'b0;
      control_reg = 16'h0;
      conf_1_reg  = 32'd0;
      conf_2_reg  = 32'd0;
      conf_3_reg  = 32'd0;
      ext_trig    = 1'b0;
      repeat (3) step();
      chk("rst_pulse", {31'd0, pulse_out}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_cycles", cycles_done, 32'd0);
      chk("rst_status", {16'd0, status_reg}, 32'd0);
      rst_n       = 1'b1;
      control_reg = 16'h0001;

      // hi=3 lo=2 n=2, explicit waveform
      conf_1_reg = 32'd3;
      conf_2_reg = 32'd2;
      conf_3_reg = 32'd2;
      repeat (2) step();
      start_sw("t1");
      pat1 = 10'b1110011100;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("t1_pulse", {31'd0, pulse_out}, {31'd0, pat1[9-i]});
         chk("t1_nodone", {31'd0, done}, 32'd0);
         if (i == 0) chk("t1_st_high", {16'd0, status_reg}, 32'h9000);
         if (i == 3) chk("t1_st_low", {16'd0, status_reg}, 32'hA000);
      end
      step();
      chk("t1_done", {31'd0, done}, 32'd1);
      chk("t1_busy_fall", {31'd0, busy}, 32'd0);
      chk("t1_cycles", cycles_done, 32'd2);
      chk("t1_status", {16'd0, status_reg}, 32'h0000);
      step();
      chk("t1_done_1cyc", {31'd0, done}, 32'd0);

      // zero counts clamp to 1
      conf_1_reg = 32'd0;
      conf_2_reg = 32'd0;
      conf_3_reg = 32'd3;
      start_sw("t2");
      run_burst("t2", 1, 1, 3);

      // continuous, then abort
      conf_1_reg = 32'd1;
      conf_2_reg = 32'd1;
      conf_3_reg = 32'd0;
      start_sw("t3");
      for (int i = 0; i < 100; i++) begin
         step();
         chk("t3_pulse", {31'd0, pulse_out}, (i % 2 == 0) ? 32'd1 : 32'd0);
      end
      chk("t3_cycles", cycles_done, 32'd49);
      control_reg = 16'h0000;
      step();
      chk("t3_ab_pulse", {31'd0, pulse_out}, 32'd0);
      chk("t3_ab_busy", {31'd0, busy}, 32'd0);
      chk("t3_ab_done", {31'd0, done}, 32'd0);
      chk("t3_ab_status", {16'd0, status_reg}, 32'h4000);
      chk("t3_ab_cycles", cycles_done, 32'd49);
      step();
      chk("t3_ab_done2", {31'd0, done}, 32'd0);
      chk("t3_ab_hold", cycles_done, 32'd49);
      control_reg = 16'h0001;
      step();

      // mid-burst config rewrite and retrigger
      conf_1_reg = 32'd3;
      conf_2_reg = 32'd2;
      conf_3_reg = 32'd2;
      start_sw("t4");
      chk("t4_abort_clr", {31'd0, status_reg[14]}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         step();
         if (i == 0) chk("t4_abort_clr", {31'd0, status_reg[14]}, 32'd0);
         chk("t4_pulse", {31'd0, pulse_out}, ((i % 5) < 3) ? 32'd1 : 32'd0);
         if (i == 1) begin
            conf_1_reg     = 32'd10;
            control_reg[1] = 1'b1;
         end
         if (i == 4) control_reg[1] = 1'b0;
      end
      step();
      chk("t4_done", {31'd0, done}, 32'd1);
      repeat (4) step();
      chk("t4_no_restart", {31'd0, busy}, 32'd0);
      start_sw("t4b");
      run_burst("t4b", 10, 2, 2);

      // external trigger, falling edge mode
      conf_1_reg  = 32'd2;
      conf_2_reg  = 32'd1;
      conf_3_reg  = 32'd1;
      control_reg = 16'h000D;
      ext_trig    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t5_rise_ign", {31'd0, busy}, 32'd0);
      end
      ext_trig = 1'b0;
      step();
      chk("t5_lat1", {31'd0, busy}, 32'd0);
      step();
      chk("t5_lat2", {31'd0, busy}, 32'd0);
      step();
      chk("t5_start", {31'd0, busy}, 32'd1);
      chk("t5_pulse", {31'd0, pulse_out}, 32'd1);
      repeat (2) step();
      step();
      chk("t5_done", {31'd0, done}, 32'd1);
      chk("t5_cycles", cycles_done, 32'd1);
      control_reg = 16'h0009;
      ext_trig    = 1'b1;
      repeat (4) step();
      ext_trig = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t5_masked", {31'd0, busy}, 32'd0);
      end

      // reset in HIGH, then trigger held through reset
      conf_1_reg  = 32'd5;
      conf_2_reg  = 32'd1;
      conf_3_reg  = 32'd0;
      control_reg = 16'h0001;
      start_sw("t6");
      repeat (2) step();
      chk("t6_in_high", {31'd0, pulse_out}, 32'd1);
      rst_n = 1'b0;
      step();
      chk("t6_rst_pulse", {31'd0, pulse_out}, 32'd0);
      chk("t6_rst_busy", {31'd0, busy}, 32'd0);
      chk("t6_rst_status", {16'd0, status_reg}, 32'd0);
      chk("t6_rst_cycles", cycles_done, 32'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t6_stay_idle", {31'd0, busy}, 32'd0);
      end
      rst_n       = 1'b0;
      control_reg = 16'h0003;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      chk("t6_held_a", {31'd0, busy}, 32'd0);
      step();
      chk("t6_held_b", {31'd0, busy}, 32'd0);
      step();
      chk("t6_held_fire", {31'd0, busy}, 32'd1);
      control_reg = 16'h0000;
      step();
      chk("t6_final_idle", {31'd0, busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
